// File: rtl/plurality_vote_tally.sv
// plurality_vote_tally
// Streaming plurality voter: accepts one ballot per cycle over valid/ready,
// keeps one tally counter per candidate, and on a close request scans the
// tallies one candidate per cycle to find the plurality winner.
// Ties resolve to the lowest candidate index.
// Optional feature macro: VOTE_TIE_FLAG_EN adds a 'tie' output that flags
// a later candidate matching the final (non-zero) winning count.
module plurality_vote_tally #(
  parameter int NUM_CAND   = 4,
  parameter int CAND_W     = $clog2(NUM_CAND),
  parameter int MAX_VOTERS = 8,
  parameter int CNT_W      = $clog2(MAX_VOTERS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vote_valid,
  output logic              vote_ready,
  input  logic [CAND_W-1:0] vote_cand,
  input  logic              close_req,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CAND_W-1:0] winner,
  output logic [CNT_W-1:0]  winner_count,
  output logic [CNT_W-1:0]  total_count,
  output logic              reject_err
`ifdef VOTE_TIE_FLAG_EN
  ,
  output logic              tie
`endif
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    RESULT  = 2'd2
  } state_t;

  // Constants sized to the operands they are compared against, so every
  // compare is unsigned and width-matched.
  localparam logic [CNT_W-1:0]  MAX_V    = CNT_W'(MAX_VOTERS);
  localparam logic [CAND_W:0]   NUM_C    = (CAND_W + 1)'(NUM_CAND);
  localparam logic [CAND_W-1:0] LAST_IDX = CAND_W'(NUM_CAND - 1);

  state_t            state;
  state_t            state_next;

  logic [CNT_W-1:0]  tally [NUM_CAND];
  logic [CNT_W-1:0]  total_q;
  logic              reject_q;

  logic [CAND_W-1:0] scan_idx;
  logic [CAND_W-1:0] best_idx;
  logic [CNT_W-1:0]  best_count;
  logic              tie_q;

  logic              accept;
  logic              in_range;
  logic              close_take;
  logic              scan_last;
  logic              result_xfer;
  logic [CNT_W-1:0]  scan_tally;

  // Handshake qualifiers and scan helpers derived from the current state.
  always_comb begin
    vote_ready  = 1'b0;
    accept      = 1'b0;
    in_range    = 1'b0;
    close_take  = 1'b0;
    scan_last   = 1'b0;
    result_xfer = 1'b0;
    scan_tally  = '0;
    if (state == COLLECT) begin
      vote_ready = (total_q < MAX_V);
      close_take = close_req;
    end
    accept      = vote_valid && vote_ready;
    in_range    = ({1'b0, vote_cand} < NUM_C);
    scan_last   = (scan_idx == LAST_IDX);
    result_xfer = (state == RESULT) && result_ready;
    if (state == SCAN) begin
      scan_tally = tally[scan_idx];
    end
  end

  // State register; reset aborts any scan or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: close starts the scan, the last index ends it, and
  // the result handshake returns to collecting ballots.
  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT: begin
        if (close_take) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (scan_last) begin
          state_next = RESULT;
        end
      end
      RESULT: begin
        if (result_xfer) begin
          state_next = COLLECT;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  // Per-candidate tallies: bump on an accepted in-range ballot, clear when
  // the result has been handed off.
  always_ff @(posedge clk) begin
    if (rst || result_xfer) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        tally[i] <= '0;
      end
    end else if (accept && in_range) begin
      tally[vote_cand] <= tally[vote_cand] + CNT_W'(1);
    end
  end

  // Total of counted ballots plus the sticky out-of-range flag.
  always_ff @(posedge clk) begin
    if (rst || result_xfer) begin
      total_q  <= '0;
      reject_q <= 1'b0;
    end else if (accept) begin
      if (in_range) begin
        total_q <= total_q + CNT_W'(1);
      end else begin
        reject_q <= 1'b1;
      end
    end
  end

  // Sequential scan: keep the running best, replacing it only on a strictly
  // larger tally so the lowest index wins ties; the tie tracker restarts
  // whenever the best changes.
  always_ff @(posedge clk) begin
    if (rst || result_xfer) begin
      scan_idx   <= '0;
      best_idx   <= '0;
      best_count <= '0;
      tie_q      <= 1'b0;
    end else if (close_take) begin
      scan_idx   <= '0;
      best_idx   <= '0;
      best_count <= '0;
      tie_q      <= 1'b0;
    end else if (state == SCAN) begin
      if (scan_tally > best_count) begin
        best_idx   <= scan_idx;
        best_count <= scan_tally;
        tie_q      <= 1'b0;
      end else if ((scan_tally == best_count) && (best_count != '0)) begin
        tie_q <= 1'b1;
      end
      if (!scan_last) begin
        scan_idx <= scan_idx + CAND_W'(1);
      end
    end
  end

  assign busy         = (state != COLLECT);
  assign result_valid = (state == RESULT);
  assign winner       = best_idx;
  assign winner_count = best_count;
  assign total_count  = total_q;
  assign reject_err   = reject_q;

`ifdef VOTE_TIE_FLAG_EN
  assign tie = tie_q;
`else
  // Without the tie output the tracker has no observer; folding it here
  // keeps the register referenced so the build stays warning-free.
  logic tie_unused;
  assign tie_unused = tie_q;
`endif

endmodule

// File: tb/tb_plurality_vote_tally.sv
// tb_plurality_vote_tally
// Directed bench for plurality_vote_tally: a 4-candidate / 8-voter instance
// for the main scenarios and a 3-candidate instance for out-of-range ballots.
// Optional feature macro: VOTE_TIE_FLAG_EN also checks the tie output.
module tb_plurality_vote_tally;

  localparam int NC  = 4;
  localparam int MV  = 8;
  localparam int CW  = 2;
  localparam int NW  = 4;
  localparam int NC3 = 3;
  localparam int CW3 = 2;

  logic clk = 1'b0;
  logic rst;

  logic          vote_valid, vote_ready, close_req, busy, result_valid, result_ready;
  logic [CW-1:0] vote_cand, winner;
  logic [NW-1:0] winner_count, total_count;
  logic          reject_err;

  logic           v3_valid, v3_ready, close3, busy3, rv3, rr3;
  logic [CW3-1:0] v3_cand, winner3;
  logic [NW-1:0]  wcount3, total3;
  logic           reject3;

`ifdef VOTE_TIE_FLAG_EN
  logic tie, tie3;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  plurality_vote_tally #(.NUM_CAND(NC), .MAX_VOTERS(MV)) dut (
    .clk(clk), .rst(rst),
    .vote_valid(vote_valid), .vote_ready(vote_ready), .vote_cand(vote_cand),
    .close_req(close_req), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .winner(winner), .winner_count(winner_count),
    .total_count(total_count), .reject_err(reject_err)
`ifdef VOTE_TIE_FLAG_EN
    , .tie(tie)
`endif
  );

  plurality_vote_tally #(.NUM_CAND(NC3), .MAX_VOTERS(MV)) dut3 (
    .clk(clk), .rst(rst),
    .vote_valid(v3_valid), .vote_ready(v3_ready), .vote_cand(v3_cand),
    .close_req(close3), .busy(busy3),
    .result_valid(rv3), .result_ready(rr3),
    .winner(winner3), .winner_count(wcount3),
    .total_count(total3), .reject_err(reject3)
`ifdef VOTE_TIE_FLAG_EN
    , .tie(tie3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_ballot(input logic [CW-1:0] cand);
    vote_valid = 1'b1;
    vote_cand  = cand;
    step();
    vote_valid = 1'b0;
  endtask

  task automatic send_ballot3(input logic [CW3-1:0] cand);
    v3_valid = 1'b1;
    v3_cand  = cand;
    step();
    v3_valid = 1'b0;
  endtask

  // Pulse close for one cycle, then count cycles until result_valid; the
  // close cycle itself counts as cycle 1. Bounded so a hung scan still ends.
  task automatic close_and_wait(input bit on3, output int cycles);
    if (on3) close3 = 1'b1; else close_req = 1'b1;
    step();
    close3    = 1'b0;
    close_req = 1'b0;
    cycles = 1;
    while (((on3 ? rv3 : result_valid) !== 1'b1) && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  task automatic apply_stimulus_xfer();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    vote_valid = 1'b0; vote_cand = '0; close_req = 1'b0; result_ready = 1'b0;
    v3_valid = 1'b0; v3_cand = '0; close3 = 1'b0; rr3 = 1'b0;
    step();
    step();
    rst = 1'b0;

    $display("[TB] reset state");
    check_output("rst_vote_ready", vote_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_result_valid", result_valid, 0);
    check_output("rst_winner", winner, 0);
    check_output("rst_winner_count", winner_count, 0);
    check_output("rst_total", total_count, 0);
    check_output("rst_reject", reject_err, 0);
    check_output("rst3_vote_ready", v3_ready, 1);

    $display("[TB] election 1: 2,2,1,3,2 then 0 together with close");
    send_ballot(2); send_ballot(2); send_ballot(1); send_ballot(3); send_ballot(2);
    check_output("e1_total_before_close", total_count, 5);
    vote_valid = 1'b1;
    vote_cand  = 2'd0;
    close_and_wait(1'b0, lat);
    vote_valid = 1'b0;
    check_output("e1_latency", lat, 5);
    check_output("e1_winner", winner, 2);
    check_output("e1_winner_count", winner_count, 3);
    check_output("e1_total", total_count, 6);
    check_output("e1_reject", reject_err, 0);
    check_output("e1_busy_result", busy, 1);
    check_output("e1_ready_result", vote_ready, 0);
`ifdef VOTE_TIE_FLAG_EN
    check_output("e1_tie", tie, 0);
`endif
    apply_stimulus_xfer();
    check_output("e1_rv_after_xfer", result_valid, 0);
    check_output("e1_ready_after_xfer", vote_ready, 1);
    check_output("e1_total_after_xfer", total_count, 0);

    $display("[TB] election 2: 1,3,1,3 with result_ready held high");
    send_ballot(1); send_ballot(3); send_ballot(1); send_ballot(3);
    result_ready = 1'b1;
    close_and_wait(1'b0, lat);
    check_output("e2_latency", lat, 5);
    check_output("e2_winner", winner, 1);
    check_output("e2_winner_count", winner_count, 2);
    check_output("e2_total", total_count, 4);
`ifdef VOTE_TIE_FLAG_EN
    check_output("e2_tie", tie, 1);
`endif
    step();
    result_ready = 1'b0;
    check_output("e2_rv_one_cycle", result_valid, 0);
    check_output("e2_ready_after_xfer", vote_ready, 1);

    $display("[TB] election 3: nine ballots for candidate 0 back-to-back");
    vote_valid = 1'b1;
    vote_cand  = 2'd0;
    repeat (7) step();
    check_output("e3_ready_at_7", vote_ready, 1);
    check_output("e3_total_at_7", total_count, 7);
    step();
    check_output("e3_ready_at_8", vote_ready, 0);
    check_output("e3_total_at_8", total_count, 8);
    step();
    step();
    check_output("e3_ninth_held", total_count, 8);
    close_and_wait(1'b0, lat);
    vote_valid = 1'b0;
    check_output("e3_latency", lat, 5);
    check_output("e3_winner", winner, 0);
    check_output("e3_winner_count", winner_count, 8);
    check_output("e3_total", total_count, 8);
    apply_stimulus_xfer();
    check_output("e3_ready_after_xfer", vote_ready, 1);

    $display("[TB] election 4: three candidates, ballots 3 then 0");
    send_ballot3(3);
    check_output("e4_reject_set", reject3, 1);
    check_output("e4_total_after_reject", total3, 0);
    send_ballot3(0);
    close_and_wait(1'b1, lat);
    check_output("e4_latency", lat, 4);
    check_output("e4_winner", winner3, 0);
    check_output("e4_winner_count", wcount3, 1);
    check_output("e4_total", total3, 1);
    check_output("e4_reject", reject3, 1);
    rr3 = 1'b1;
    step();
    rr3 = 1'b0;
    check_output("e4_reject_cleared", reject3, 0);
    check_output("e4_ready_after_xfer", v3_ready, 1);

    $display("[TB] election 5: no ballots, result held for 10 cycles");
    close_and_wait(1'b0, lat);
    check_output("e5_latency", lat, 5);
    for (int i = 0; i < 10; i++) begin
      check_output("e5_hold_rv", result_valid, 1);
      check_output("e5_hold_winner", winner, 0);
      check_output("e5_hold_count", winner_count, 0);
      check_output("e5_hold_total", total_count, 0);
`ifdef VOTE_TIE_FLAG_EN
      check_output("e5_hold_tie", tie, 0);
`endif
      step();
    end
    check_output("e5_still_valid", result_valid, 1);
    apply_stimulus_xfer();
    check_output("e5_rv_after_xfer", result_valid, 0);
    check_output("e5_ready_after_xfer", vote_ready, 1);
    check_output("e5_busy_after_xfer", busy, 0);

    $display("[TB] election 6: reset during scan, then fresh election");
    send_ballot(1); send_ballot(1);
    close_req = 1'b1;
    step();
    close_req = 1'b0;
    check_output("e6_busy_scan", busy, 1);
    check_output("e6_ready_scan", vote_ready, 0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("e6_rst_ready", vote_ready, 1);
    check_output("e6_rst_busy", busy, 0);
    check_output("e6_rst_rv", result_valid, 0);
    check_output("e6_rst_winner", winner, 0);
    check_output("e6_rst_count", winner_count, 0);
    check_output("e6_rst_total", total_count, 0);
    check_output("e6_rst_reject", reject_err, 0);
    repeat (6) step();
    check_output("e6_no_stale_result", result_valid, 0);
    send_ballot(3);
    close_and_wait(1'b0, lat);
    check_output("e6_latency", lat, 5);
    check_output("e6_winner", winner, 3);
    check_output("e6_winner_count", winner_count, 1);
    check_output("e6_total", total_count, 1);
    apply_stimulus_xfer();
    check_output("e6_ready_after_xfer", vote_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plurality_vote_tally.md
Name: plurality_vote_tally

Overview:
- Streaming, parametrised successor to the team's fixed-size combinational plurality voter.
- Accepts one ballot per cycle over a valid/ready handshake and keeps one tally counter per candidate.
- On a close request, scans the tallies sequentially and emits the plurality winner with its count.
- Sits between the ballot input share-decoder and the MPC result stage; candidate count and electorate size are parameters instead of being fixed.

Parameters:
- NUM_CAND, 4, number of candidates (2..16).
- CAND_W, $clog2(NUM_CAND), width of a candidate index.
- MAX_VOTERS, 8, maximum ballots accepted per election (1..65535).
- CNT_W, $clog2(MAX_VOTERS+1), width of each tally counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- vote_valid, input, 1, ballot present.
- vote_ready, output, 1, ballot can be accepted.
- vote_cand, input, CAND_W, candidate index of the ballot.
- close_req, input, 1, end-of-election pulse; sampled only in COLLECT.
- busy, output, 1, high in SCAN and RESULT.
- result_valid, output, 1, winner outputs valid.
- result_ready, input, 1, consumer accepts the result.
- winner, output, CAND_W, winning candidate index.
- winner_count, output, CNT_W, tally of the winner.
- total_count, output, CNT_W, valid ballots counted.
- reject_err, output, 1, sticky: an out-of-range ballot was seen this election.

Behaviour:
- Reset: every output and internal register goes to 0, except vote_ready, which is 1. State is COLLECT. Reset asserted mid-scan or mid-result aborts and clears everything on the next edge.
- States: COLLECT, SCAN, RESULT.
- COLLECT, acceptance:
  - vote_ready = (total_count < MAX_VOTERS).
  - A ballot is accepted when vote_valid & vote_ready.
  - If vote_cand < NUM_CAND: tally[vote_cand] += 1 and total_count += 1.
  - Otherwise the ballot is consumed but not counted, and reject_err is set.
- COLLECT, full: at total_count == MAX_VOTERS, vote_ready = 0. Held ballots are not consumed.
- COLLECT, close:
  - close_req = 1 moves to SCAN.
  - A ballot accepted in the same cycle as close_req is counted before the scan.
  - vote_ready = 0 from the cycle after close.
- SCAN:
  - Examines one candidate per cycle, index 0..NUM_CAND-1, over exactly NUM_CAND cycles.
  - Running best is replaced only if tally[i] > best_count (strict). Ties therefore resolve to the lowest index.
  - Zero ballots gives winner 0, winner_count 0.
  - After the last index, moves to RESULT.
- Latency: result_valid rises NUM_CAND+1 cycles after the cycle close_req is sampled.
- RESULT:
  - winner, winner_count, total_count and reject_err are held stable while result_valid = 1.
  - On result_valid & result_ready: all tallies, total_count and reject_err clear, and the state returns to COLLECT.
  - vote_ready = 1 on the next cycle.
  - result_ready asserted in the same cycle result_valid first rises completes the transfer in that cycle.
- Ignored inputs: close_req outside COLLECT. vote_valid while vote_ready = 0 (ballot not consumed).
- Arithmetic: tallies cannot overflow, because total ≤ MAX_VOTERS fits CNT_W. All compares are unsigned.

Optional Feature:
- Macro: VOTE_TIE_FLAG_EN.
- When defined:
  - Adds output tie, 1 bit, valid with result_valid.
  - tie = 1 when a later candidate's tally equals the running best during SCAN, and that best is the final winner_count (> 0).
  - The tie tracker resets whenever the best is replaced.
  - Winner selection is unchanged (lowest index).
- When undefined: the port and logic are absent, and all other behaviour is identical.

Test Plan (NUM_CAND=4, MAX_VOTERS=8):
- Ballots 2,2,1,3,2,0, then close_req -> result_valid 5 cycles after close; winner=2, winner_count=3, total_count=6, reject_err=0.
- Ballots 1,3,1,3, then close -> winner=1, winner_count=2; tie=1 when VOTE_TIE_FLAG_EN is defined.
- 9 ballots of candidate 0 offered back-to-back -> vote_ready drops after the 8th; the 9th is held and not consumed. Close -> winner=0, count=8.
- CAND_W is 2, so NUM_CAND=4 cannot produce an out-of-range index. Rerun with NUM_CAND=3, ballots 3,0 -> reject_err=1, total_count=1, winner=0, count=1.
- Close with no ballots, result_ready held low 10 cycles -> winner=0, count=0, outputs stable. Raise result_ready -> back to COLLECT, vote_ready=1 next cycle.
- rst pulsed during SCAN after ballots 1,1 -> all outputs 0, vote_ready=1. A new election with ballot 3 -> winner=3, count=1.
